// File: rtl/i2c_byte_master_if.sv
// i2c_byte_master_if: command handshake and open-drain bus signals of the I2C byte master
interface i2c_byte_master_if;
    logic       I_CMD_VALID;
    logic [1:0] I_CMD;
    logic [7:0] I_TX_BYTE;
    logic       I_RX_ACK;
    logic       I_SDA;
    logic       I_SCL;
    logic       O_CMD_READY;
    logic       O_DONE;
    logic       O_BUSY;
    logic [7:0] O_RX_BYTE;
    logic       O_ACK_RECEIVED;
    logic       O_SDA_T;
    logic       O_SCL_T;

    modport master (
        input  I_CMD_VALID, I_CMD, I_TX_BYTE, I_RX_ACK, I_SDA, I_SCL,
        output O_CMD_READY, O_DONE, O_BUSY, O_RX_BYTE, O_ACK_RECEIVED, O_SDA_T, O_SCL_T
    );

    modport slave (
        output I_CMD_VALID, I_CMD, I_TX_BYTE, I_RX_ACK, I_SDA, I_SCL,
        input  O_CMD_READY, O_DONE, O_BUSY, O_RX_BYTE, O_ACK_RECEIVED, O_SDA_T, O_SCL_T
    );
endinterface

// File: rtl/i2c_byte_master.sv
// i2c_byte_master: byte-level I2C master (START/STOP/WRITE/READ); define I2C_CLOCK_STRETCH_EN for slave clock stretching
module i2c_byte_master #(
    parameter int P_CLK_DIV   = 125,
    parameter int P_DIV_WIDTH = 8
) (
    input logic               I_CLK,
    input logic               I_RESET,
    i2c_byte_master_if.master bus
);
    typedef enum logic [2:0] {S_IDLE, S_NOP, S_START, S_WRITE, S_READ, S_STOP} state_t;

    localparam logic [P_DIV_WIDTH-1:0] L_LOAD = P_DIV_WIDTH'(P_CLK_DIV - 1);

    state_t                 state_q, state_d;
    logic [1:0]             ph_q, ph_d;
    logic [3:0]             bit_q, bit_d;
    logic [P_DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [7:0]             tx_q, tx_d;
    logic [7:0]             sh_q, sh_d;
    logic [7:0]             rx_q, rx_d;
    logic                   rack_q, rack_d;
    logic                   ack_q, ack_d;
    logic                   busy_q, busy_d;
    logic                   rdy_q, rdy_d;
    logic                   done_q, done_d;
    logic                   sda_q, sda_d;
    logic                   scl_q, scl_d;
    logic                   stall;

`ifdef I2C_CLOCK_STRETCH_EN
    assign stall = state_q != S_IDLE && state_q != S_NOP && ph_q == 2'd2 && scl_q && !bus.I_SCL;
`else
    logic unused_scl;
    assign unused_scl = bus.I_SCL;
    assign stall = 1'b0;
`endif

    // Next-state: command accept, phase/bit sequencing, sampling, then line levels for the coming phase
    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        bit_d   = bit_q;
        cnt_d   = cnt_q;
        tx_d    = tx_q;
        sh_d    = sh_q;
        rx_d    = rx_q;
        rack_d  = rack_q;
        ack_d   = ack_q;
        busy_d  = busy_q;
        rdy_d   = rdy_q;
        done_d  = 1'b0;
        sda_d   = sda_q;
        scl_d   = scl_q;
        case (state_q)
            S_IDLE: if (bus.I_CMD_VALID && rdy_q) begin
                rdy_d  = 1'b0;
                tx_d   = bus.I_TX_BYTE;
                rack_d = bus.I_RX_ACK;
                ph_d   = 2'd0;
                bit_d  = 4'd0;
                cnt_d  = L_LOAD;
                if (bus.I_CMD == 2'd0) begin
                    state_d = S_START;
                    busy_d  = 1'b1;
                end else if (!busy_q) begin
                    state_d = S_NOP;
                    ack_d   = 1'b1;
                end else begin
                    state_d = bus.I_CMD == 2'd1 ? S_STOP : bus.I_CMD == 2'd2 ? S_WRITE : S_READ;
                end
            end
            S_NOP: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                rdy_d   = 1'b1;
            end
            default: if (!stall) begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - P_DIV_WIDTH'(1);
                end else begin
                    cnt_d = L_LOAD;
                    ph_d  = ph_q + 2'd1;
                    if (ph_q == 2'd3) begin
                        bit_d = bit_q + 4'd1;
                        if (state_q == S_WRITE) tx_d = {tx_q[6:0], 1'b0};
                        if (state_q == S_WRITE && bit_q == 4'd8) ack_d = bus.I_SDA;
                        if (state_q == S_READ && bit_q != 4'd8) sh_d = {sh_q[6:0], bus.I_SDA};
                        if (state_q == S_READ && bit_q == 4'd8) rx_d = sh_q;
                        if (state_q == S_START || state_q == S_STOP || bit_q == 4'd8) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                            rdy_d   = 1'b1;
                            busy_d  = state_q != S_STOP;
                        end
                    end
                end
            end
        endcase
        case (state_d)
            S_START: begin
                sda_d = !ph_d[1];
                scl_d = ph_d == 2'd0 ? scl_q : ph_d != 2'd3;
            end
            S_STOP: begin
                sda_d = ph_d[1];
                scl_d = ph_d != 2'd0;
            end
            S_WRITE: begin
                sda_d = bit_d == 4'd8 || tx_d[7];
                scl_d = ph_d[1];
            end
            S_READ: begin
                sda_d = bit_d == 4'd8 ? rack_d : 1'b1;
                scl_d = ph_d[1];
            end
            default: ;
        endcase
    end

    // State and registered outputs; reset releases both lines immediately
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            state_q <= S_IDLE;
            ph_q    <= 2'd0;
            bit_q   <= 4'd0;
            cnt_q   <= '0;
            tx_q    <= 8'h00;
            sh_q    <= 8'h00;
            rx_q    <= 8'h00;
            rack_q  <= 1'b1;
            ack_q   <= 1'b1;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b1;
            done_q  <= 1'b0;
            sda_q   <= 1'b1;
            scl_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
            sh_q    <= sh_d;
            rx_q    <= rx_d;
            rack_q  <= rack_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            rdy_q   <= rdy_d;
            done_q  <= done_d;
            sda_q   <= sda_d;
            scl_q   <= scl_d;
        end
    end

    assign bus.O_CMD_READY    = rdy_q;
    assign bus.O_DONE         = done_q;
    assign bus.O_BUSY         = busy_q;
    assign bus.O_RX_BYTE      = rx_q;
    assign bus.O_ACK_RECEIVED = ack_q;
    assign bus.O_SDA_T        = sda_q;
    assign bus.O_SCL_T        = scl_q;
endmodule

// File: tb/tb_i2c_byte_master.sv
// tb_i2c_byte_master: directed checks of the I2C byte master with a small open-drain slave model
module tb_i2c_byte_master;
    logic I_CLK = 1'b0;
    logic I_RESET;
    always #5 I_CLK = ~I_CLK;

    i2c_byte_master_if bus();
    i2c_byte_master #(.P_CLK_DIV(4), .P_DIV_WIDTH(8)) dut (.I_CLK(I_CLK), .I_RESET(I_RESET), .bus(bus));

    logic pull, stretch, stretch_req;
    assign bus.I_SDA = bus.O_SDA_T & ~pull;
    assign bus.I_SCL = bus.O_SCL_T & ~stretch;

    int checks, errors, lat, rises, falls, toggles, rdy_hi, sda_fall_at, scl_fall_at, scnt, mode;
    logic sda_fall_scl, sda_rise_scl, psda, pscl;
    logic [15:0] bits;
    logic [7:0] rdat;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Observe lines at a negedge n cycles after accept and drive the slave model
    task automatic track(input int n);
        logic sda, scl, rise;
        sda = bus.O_SDA_T;
        scl = bus.O_SCL_T;
        rise = scl && !pscl;
        if (scl !== pscl) toggles++;
        if (sda !== psda) toggles++;
        if (rise) begin
            rises++;
            bits = {bits[14:0], sda};
        end
        if (!scl && pscl) begin
            falls++;
            if (scl_fall_at < 0) scl_fall_at = n;
        end
        if (!sda && psda && sda_fall_at < 0) begin
            sda_fall_at = n;
            sda_fall_scl = scl;
        end
        if (sda && !psda) sda_rise_scl = scl;
        if (bus.O_CMD_READY && !bus.O_DONE) rdy_hi++;
        if (scnt > 0) begin
            scnt--;
            if (scnt == 0) stretch = 1'b0;
        end else if (stretch_req && rise && rises == 4) begin
            stretch = 1'b1;
            scnt = 20;
            stretch_req = 1'b0;
        end
        pull = (mode == 1 && falls == 8) || (mode == 2 && falls < 8 && !rdat[7 - falls]);
        psda = sda;
        pscl = scl;
    endtask

    task automatic issue(input logic [1:0] cmd, input logic [7:0] tx, input logic rack, input logic hold, input int m);
        @(negedge I_CLK);
        bus.I_CMD_VALID = 1'b1;
        bus.I_CMD = cmd;
        bus.I_TX_BYTE = tx;
        bus.I_RX_ACK = rack;
        mode = m;
        rises = 0;
        falls = 0;
        toggles = 0;
        rdy_hi = 0;
        sda_fall_at = -1;
        scl_fall_at = -1;
        bits = '0;
        sda_fall_scl = 1'b0;
        sda_rise_scl = 1'b0;
        psda = bus.O_SDA_T;
        pscl = bus.O_SCL_T;
        @(negedge I_CLK);
        if (hold) bus.I_CMD = 2'd0;
        else bus.I_CMD_VALID = 1'b0;
        chk("rdy_drop", bus.O_CMD_READY, 0);
        track(0);
    endtask

    task automatic run(input int limit, output int l);
        l = 0;
        while (!bus.O_DONE && l < limit) begin
            @(negedge I_CLK);
            l++;
            track(l);
        end
        bus.I_CMD_VALID = 1'b0;
        mode = 0;
        pull = 1'b0;
        if (!bus.O_DONE) chk("timeout", bus.O_DONE, 1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        I_RESET = 1'b1;
        bus.I_CMD_VALID = 1'b0;
        bus.I_CMD = 2'd0;
        bus.I_TX_BYTE = 8'h00;
        bus.I_RX_ACK = 1'b0;
        pull = 1'b0;
        stretch = 1'b0;
        stretch_req = 1'b0;
        mode = 0;
        scnt = 0;
        rdat = 8'h00;
        repeat (3) @(negedge I_CLK);
        I_RESET = 1'b0;
        chk("rst_sda", bus.O_SDA_T, 1);
        chk("rst_scl", bus.O_SCL_T, 1);
        chk("rst_rdy", bus.O_CMD_READY, 1);
        chk("rst_busy", bus.O_BUSY, 0);
        chk("rst_done", bus.O_DONE, 0);
        chk("rst_ack", bus.O_ACK_RECEIVED, 1);
        chk("rst_rx", bus.O_RX_BYTE, 0);

        issue(2'd0, 8'h00, 1'b0, 1'b0, 0);
        run(100, lat);
        chk("st_lat", lat, 16);
        chk("st_sda_fall", sda_fall_at, 8);
        chk("st_sda_fall_scl", sda_fall_scl, 1);
        chk("st_scl_fall", scl_fall_at, 12);
        chk("st_busy", bus.O_BUSY, 1);

        issue(2'd2, 8'hA5, 1'b0, 1'b1, 1);
        run(300, lat);
        chk("wr_lat", lat, 144);
        chk("wr_bits", bits[8:0], 32'h14B);
        chk("wr_ack", bus.O_ACK_RECEIVED, 0);
        chk("wr_rdy_early", rdy_hi, 0);
        @(negedge I_CLK);
        chk("wr_not_taken", bus.O_CMD_READY, 1);
        chk("wr_busy", bus.O_BUSY, 1);

        issue(2'd0, 8'h00, 1'b0, 1'b0, 0);
        run(100, lat);
        chk("rs_lat", lat, 16);
        chk("rs_busy", bus.O_BUSY, 1);

        rdat = 8'h3C;
        issue(2'd3, 8'h00, 1'b1, 1'b0, 2);
        chk("rd_rx_pre", bus.O_RX_BYTE, 0);
        run(300, lat);
        chk("rd_lat", lat, 144);
        chk("rd_rx", bus.O_RX_BYTE, 8'h3C);
        chk("rd_sda_t", bits[8:0], 32'h1FF);
        chk("rd_ack_keep", bus.O_ACK_RECEIVED, 0);

        issue(2'd1, 8'h00, 1'b0, 1'b0, 0);
        run(100, lat);
        chk("sp_lat", lat, 16);
        chk("sp_rise_scl", sda_rise_scl, 1);
        chk("sp_busy", bus.O_BUSY, 0);
        chk("sp_sda", bus.O_SDA_T, 1);
        chk("sp_scl", bus.O_SCL_T, 1);

        issue(2'd2, 8'h55, 1'b0, 1'b0, 0);
        run(100, lat);
        chk("nop_lat", lat, 1);
        chk("nop_ack", bus.O_ACK_RECEIVED, 1);
        chk("nop_tog", toggles, 0);
        chk("nop_rx", bus.O_RX_BYTE, 8'h3C);
        chk("nop_busy", bus.O_BUSY, 0);

        issue(2'd0, 8'h00, 1'b0, 1'b0, 0);
        run(100, lat);
        stretch_req = 1'b1;
        issue(2'd2, 8'h81, 1'b0, 1'b0, 1);
        run(400, lat);
`ifdef I2C_CLOCK_STRETCH_EN
        chk("sx_lat", lat, 164);
`else
        chk("sx_lat", lat, 144);
`endif
        chk("sx_ack", bus.O_ACK_RECEIVED, 0);

        issue(2'd0, 8'h00, 1'b0, 1'b0, 0);
        run(100, lat);
        issue(2'd2, 8'hF0, 1'b0, 1'b0, 1);
        repeat (50) begin
            @(negedge I_CLK);
            track(0);
        end
        chk("mid_scl", bus.O_SCL_T, 0);
        I_RESET = 1'b1;
        @(negedge I_CLK);
        chk("mr_sda", bus.O_SDA_T, 1);
        chk("mr_scl", bus.O_SCL_T, 1);
        chk("mr_busy", bus.O_BUSY, 0);
        chk("mr_rdy", bus.O_CMD_READY, 1);
        chk("mr_ack", bus.O_ACK_RECEIVED, 1);
        chk("mr_rx", bus.O_RX_BYTE, 0);
        @(negedge I_CLK);
        I_RESET = 1'b0;
        mode = 0;
        pull = 1'b0;
        chk("mr_done", bus.O_DONE, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
